// File: rtl/pwm_decode_if.sv
// Pin-side bundle for the PWM duty decoder: two PWM channels in, recovered duty out.
// Channels are raw pins (asynchronous); duty/duty_vld/err are registered strobes.
interface pwm_decode_if #(
    parameter int MAGW = 13
);
    logic            CH_A;
    logic            CH_B;
    logic [MAGW:0]   duty;
    logic            duty_vld;
    logic            err;

    modport master (
        output CH_A,
        output CH_B,
        input  duty,
        input  duty_vld,
        input  err
    );

    modport slave (
        input  CH_A,
        input  CH_B,
        output duty,
        output duty_vld,
        output err
    );
endinterface

// File: rtl/pwm_decode.sv
// Recovers signed duty from CH_A (+) / CH_B (-) PWM pins by timing each high pulse.
// Latency: duty_vld on the 3rd clk edge counting the edge that first samples the fall (2 sync + 1 register).
// Backpressure: none; duty_vld/err are single-cycle strobes, duty holds until the next strobe.
module pwm_decode #(
    parameter int PERIOD = 8192,
    parameter int MAGW   = 13
) (
    input  logic          clk,
    input  logic          rst,
    pwm_decode_if.slave   pin
);
    localparam int DW = MAGW + 1;
    localparam int IW = $clog2(PERIOD);
    localparam logic [MAGW-1:0] WMAX = {MAGW{1'b1}};

    typedef enum logic [1:0] {LOW, HIGH_A, HIGH_B, STUCK} state_t;

    state_t          state_q, state_d;
    logic            a_s1_q, a_s1_d, a_s_q, a_s_d, a_d_q, a_d_d;
    logic            b_s1_q, b_s1_d, b_s_q, b_s_d, b_d_q, b_d_d;
    logic [MAGW-1:0] wcnt_q, wcnt_d;
    logic [IW-1:0]   icnt_q, icnt_d;
    logic [DW-1:0]   duty_q, duty_d;
    logic            duty_vld_q, duty_vld_d;
    logic            err_q, err_d;

    logic            a_rise, b_rise;

    assign a_rise = a_s_q & ~a_d_q;
    assign b_rise = b_s_q & ~b_d_q;

    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        icnt_d     = icnt_q;
        duty_d     = duty_q;
        duty_vld_d = 1'b0;
        err_d      = 1'b0;
        a_s1_d     = pin.CH_A;
        a_s_d      = a_s1_q;
        a_d_d      = a_s_q;
        b_s1_d     = pin.CH_B;
        b_s_d      = b_s1_q;
        b_d_d      = b_s_q;

        case (state_q)
            LOW: begin
                icnt_d = icnt_q + IW'(1);
                if (a_s_q && b_s_q) begin
                    err_d = 1'b1;
                end else if (a_rise) begin
                    state_d = HIGH_A;
                    wcnt_d  = MAGW'(1);
                    icnt_d  = '0;
                end else if (b_rise) begin
                    state_d = HIGH_B;
                    wcnt_d  = MAGW'(1);
                    icnt_d  = '0;
                end else if (icnt_q == IW'(PERIOD - 1)) begin
                    // Zero duty produces no pulses at all, so silence must report 0.
                    duty_d     = '0;
                    duty_vld_d = 1'b1;
                    icnt_d     = '0;
                end
            end
            HIGH_A: begin
                icnt_d = icnt_q + IW'(1);
                if (b_s_q) begin
                    err_d   = 1'b1;
                    state_d = STUCK;
                end else if (!a_s_q) begin
                    duty_d     = {1'b0, wcnt_q};
                    duty_vld_d = 1'b1;
                    state_d    = LOW;
                end else if (wcnt_q == WMAX) begin
                    duty_d     = {1'b0, WMAX};
                    duty_vld_d = 1'b1;
                    state_d    = STUCK;
                end else begin
                    wcnt_d = wcnt_q + MAGW'(1);
                end
            end
            HIGH_B: begin
                icnt_d = icnt_q + IW'(1);
                if (a_s_q) begin
                    err_d   = 1'b1;
                    state_d = STUCK;
                end else if (!b_s_q) begin
                    duty_d     = DW'(0) - {1'b0, wcnt_q};
                    duty_vld_d = 1'b1;
                    state_d    = LOW;
                end else if (wcnt_q == WMAX) begin
                    duty_d     = DW'(0) - {1'b0, WMAX};
                    duty_vld_d = 1'b1;
                    state_d    = STUCK;
                end else begin
                    wcnt_d = wcnt_q + MAGW'(1);
                end
            end
            STUCK: begin
                // Silence timing restarts once the pins are released.
                icnt_d = '0;
                if (!a_s_q && !b_s_q) begin
                    state_d = LOW;
                end
            end
            default: begin
                state_d = LOW;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= LOW;
            wcnt_q     <= '0;
            icnt_q     <= '0;
            duty_q     <= '0;
            duty_vld_q <= 1'b0;
            err_q      <= 1'b0;
            a_s1_q     <= 1'b0;
            a_s_q      <= 1'b0;
            a_d_q      <= 1'b0;
            b_s1_q     <= 1'b0;
            b_s_q      <= 1'b0;
            b_d_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            icnt_q     <= icnt_d;
            duty_q     <= duty_d;
            duty_vld_q <= duty_vld_d;
            err_q      <= err_d;
            a_s1_q     <= a_s1_d;
            a_s_q      <= a_s_d;
            a_d_q      <= a_d_d;
            b_s1_q     <= b_s1_d;
            b_s_q      <= b_s_d;
            b_d_q      <= b_d_d;
        end
    end

    assign pin.duty     = duty_q;
    assign pin.duty_vld = duty_vld_q;
    assign pin.err      = err_q;
endmodule

// File: tb/tb_pwm_decode.sv
// Bench for pwm_decode: expected duty values are queued as pulses are driven and
// popped by a negedge monitor on every duty_vld strobe.
module tb_pwm_decode;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pwm_decode_if #(.MAGW(13)) pin ();

    pwm_decode #(.PERIOD(8192), .MAGW(13)) dut (
        .clk (clk),
        .rst (rst),
        .pin (pin.slave)
    );

    int          checks  = 0;
    int          errors  = 0;
    int          cyc     = 0;
    int          vld_cnt = 0;
    int          err_cnt = 0;
    logic [13:0] exp_q[$];
    int          vld_t[$];
    logic [13:0] exp_v;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (pin.err === 1'b1) err_cnt++;
        if (pin.duty_vld === 1'b1) begin
            vld_cnt++;
            vld_t.push_back(cyc);
            checks++;
            if (pin.err !== 1'b0) begin
                errors++;
                $display("FAIL vld_with_err: err=%b required 0 at cycle %0d", pin.err, cyc);
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_vld: duty=%h with no strobe expected at cycle %0d", pin.duty, cyc);
            end else begin
                exp_v = exp_q.pop_front();
                if (pin.duty !== exp_v) begin
                    errors++;
                    $display("FAIL duty_value: got %h required %h at cycle %0d", pin.duty, exp_v, cyc);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    task automatic set_ch(input bit ch, input logic v);
        if (ch) pin.CH_B = v;
        else    pin.CH_A = v;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        pin.CH_A = 1'b0;
        pin.CH_B = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        vld_t.delete();
    endtask

    // High for hi clocks, then low for lo clocks; optionally checks strobe latency.
    task automatic pulse(input bit ch, input int hi, input int lo, input bit chk_lat);
        logic [2:0] seen;
        set_ch(ch, 1'b1);
        repeat (hi) @(negedge clk);
        set_ch(ch, 1'b0);
        if (chk_lat) begin
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                seen[k] = pin.duty_vld;
            end
            checks++;
            if (seen !== 3'b100) begin
                errors++;
                $display("FAIL latency: vld pattern after fall %b required 100", seen);
            end
            repeat (lo - 3) @(negedge clk);
        end else begin
            repeat (lo) @(negedge clk);
        end
    endtask

    task automatic end_test(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_missing_vld: %0d strobes outstanding required 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        pin.CH_A = 1'b0;
        pin.CH_B = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (pin.duty !== 14'h0000) begin
            errors++;
            $display("FAIL reset_duty: got %h required 0000", pin.duty);
        end
        checks++;
        if (pin.duty_vld !== 1'b0) begin
            errors++;
            $display("FAIL reset_vld: got %b required 0", pin.duty_vld);
        end
        checks++;
        if (pin.err !== 1'b0) begin
            errors++;
            $display("FAIL reset_err: got %b required 0", pin.err);
        end
        rst = 1'b0;
    endtask

    task automatic test_positive();
        do_reset();
        exp_q.push_back(14'h03E8);
        pulse(1'b0, 1000, 7192, 1'b1);
        exp_q.push_back(14'h03E8);
        pulse(1'b0, 1000, 20, 1'b0);
        end_test("positive");
        checks++;
        if (vld_t.size() != 2) begin
            errors++;
            $display("FAIL positive_count: got %0d strobes required 2", vld_t.size());
        end else begin
            checks++;
            if (vld_t[1] - vld_t[0] != 8192) begin
                errors++;
                $display("FAIL positive_period: got %0d required 8192", vld_t[1] - vld_t[0]);
            end
        end
    endtask

    task automatic test_negative();
        int e0;
        do_reset();
        e0 = err_cnt;
        exp_q.push_back(14'h3001);
        pulse(1'b1, 4095, 20, 1'b0);
        end_test("negative");
        checks++;
        if (err_cnt != e0) begin
            errors++;
            $display("FAIL negative_err: got %0d err strobes required 0", err_cnt - e0);
        end
    endtask

    task automatic test_min_max();
        do_reset();
        exp_q.push_back(14'd1);
        pulse(1'b0, 1, 20, 1'b0);
        exp_q.push_back(14'd8190);
        pulse(1'b0, 8190, 2, 1'b0);
        exp_q.push_back(14'd5);
        pulse(1'b0, 5, 20, 1'b0);
        end_test("min_max");
    endtask

    task automatic test_stuck();
        int v0;
        do_reset();
        v0 = vld_cnt;
        exp_q.push_back(14'd8191);
        pin.CH_A = 1'b1;
        repeat (20000) @(negedge clk);
        pin.CH_A = 1'b0;
        repeat (30) @(negedge clk);
        exp_q.push_back(14'd500);
        pulse(1'b0, 500, 20, 1'b0);
        end_test("stuck");
        checks++;
        if (vld_cnt - v0 != 2) begin
            errors++;
            $display("FAIL stuck_count: got %0d strobes required 2", vld_cnt - v0);
        end
    endtask

    task automatic test_silence();
        do_reset();
        repeat (3) exp_q.push_back(14'h0000);
        repeat (3 * 8192 + 20) @(negedge clk);
        checks++;
        if (vld_t.size() != 3) begin
            errors++;
            $display("FAIL silence_count: got %0d strobes required 3", vld_t.size());
        end else begin
            for (int k = 1; k < 3; k++) begin
                checks++;
                if (vld_t[k] - vld_t[k-1] != 8192) begin
                    errors++;
                    $display("FAIL silence_spacing: got %0d required 8192", vld_t[k] - vld_t[k-1]);
                end
            end
        end
        repeat (1000) @(negedge clk);
        exp_q.push_back(14'h3FEC);
        exp_q.push_back(14'h0000);
        pulse(1'b1, 20, 8192, 1'b0);
        end_test("silence");
        checks++;
        if (vld_t.size() != 5) begin
            errors++;
            $display("FAIL silence_restart_count: got %0d strobes required 5", vld_t.size());
        end else begin
            checks++;
            if (vld_t[4] - vld_t[3] != 8172) begin
                errors++;
                $display("FAIL silence_restart_gap: got %0d required 8172", vld_t[4] - vld_t[3]);
            end
        end
    endtask

    task automatic test_overlap();
        int e0;
        int v0;
        do_reset();
        e0 = err_cnt;
        v0 = vld_cnt;
        pin.CH_A = 1'b1;
        repeat (100) @(negedge clk);
        pin.CH_B = 1'b1;
        repeat (50) @(negedge clk);
        pin.CH_A = 1'b0;
        repeat (10) @(negedge clk);
        pin.CH_B = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (err_cnt - e0 != 1) begin
            errors++;
            $display("FAIL overlap_err: got %0d err strobes required 1", err_cnt - e0);
        end
        checks++;
        if (vld_cnt != v0) begin
            errors++;
            $display("FAIL overlap_vld: got %0d strobes required 0", vld_cnt - v0);
        end
        exp_q.push_back(14'd250);
        pulse(1'b0, 250, 20, 1'b0);
        end_test("overlap");
    endtask

    task automatic test_reset_mid();
        checks++;
        if (pin.duty !== 14'd250) begin
            errors++;
            $display("FAIL reset_mid_hold: got %h required %h", pin.duty, 14'd250);
        end
        pin.CH_A = 1'b1;
        repeat (200) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (pin.duty !== 14'h0000 || pin.duty_vld !== 1'b0 || pin.err !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_out: got duty=%h vld=%b err=%b required 0000 0 0",
                     pin.duty, pin.duty_vld, pin.err);
        end
        pin.CH_A = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        exp_q.push_back(14'd300);
        pulse(1'b0, 300, 20, 1'b0);
        end_test("reset_mid");
    endtask

    initial begin
        pin.CH_A = 1'b0;
        pin.CH_B = 1'b0;
        test_reset();
        test_positive();
        test_negative();
        test_min_max();
        test_stuck();
        test_silence();
        test_overlap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
